// File: rtl/time_adjust_ctrl.sv
// Command-side controller for the alarm clock counters: cascades the 1 Hz tick in RUN
// and turns debounced buttons into single-step / auto-repeat count pulses in SET modes.
module time_adjust_ctrl #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_c,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       sec_tc,
  input  logic       min_tc,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       up_down,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_CYCLES);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_BAD     = 2'b11
  } mode_t;

  mode_t             mode_q, mode_d;
  logic              sec_en_q, sec_en_d;
  logic              min_en_q, min_en_d;
  logic              hr_en_q, hr_en_d;
  logic              up_down_q, up_down_d;
  logic              blink_q, blink_d;
  logic              btn_c_q, btn_u_q, btn_d_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [REP_W-1:0]  rep_q, rep_d;

  logic c_rise, u_rise, d_rise;
  logic in_set, one_held;
  logic step_fire, rep_fire, cnt_fire;

  always_comb begin
    c_rise   = btn_c & ~btn_c_q;
    u_rise   = btn_u & ~btn_u_q;
    d_rise   = btn_d & ~btn_d_q;
    in_set   = (mode_q == MODE_SET_HR) || (mode_q == MODE_SET_MIN);
    one_held = btn_u ^ btn_d;

    hold_d   = '0;
    rep_d    = '0;
    rep_fire = 1'b0;

    // Hold/repeat only run while exactly one count button is held in a SET mode
    // and no mode change is pending; any other situation restarts them from zero.
    if (in_set && !c_rise && one_held) begin
      if (hold_q < HOLD_MAX) begin
        hold_d   = hold_q + HOLD_W'(1);
        rep_fire = ((hold_q + HOLD_W'(1)) == HOLD_MAX);
      end else begin
        hold_d = hold_q;
        if ((rep_q + REP_W'(1)) >= REP_MAX) begin
          rep_fire = 1'b1;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end
    end

    // With both buttons down the edge of the second one must not count.
    step_fire = (u_rise | d_rise) & one_held & in_set & ~c_rise;
    cnt_fire  = step_fire | rep_fire;

    mode_d    = mode_q;
    sec_en_d  = 1'b0;
    min_en_d  = 1'b0;
    hr_en_d   = 1'b0;
    up_down_d = up_down_q;
    blink_d   = blink_q;

    case (mode_q)
      MODE_RUN: begin
        up_down_d = 1'b1;
        blink_d   = 1'b0;
        sec_en_d  = tick_1hz;
        min_en_d  = tick_1hz & sec_tc;
        hr_en_d   = tick_1hz & sec_tc & min_tc;
        if (c_rise) mode_d = MODE_SET_HR;
      end
      MODE_SET_HR: begin
        if (c_rise) begin
          mode_d  = MODE_SET_MIN;
          blink_d = 1'b0;
        end else begin
          if (tick_1hz) blink_d = ~blink_q;
          if (cnt_fire) begin
            hr_en_d   = 1'b1;
            up_down_d = btn_u;
          end
        end
      end
      MODE_SET_MIN: begin
        if (c_rise) begin
          mode_d  = MODE_RUN;
          blink_d = 1'b0;
        end else begin
          if (tick_1hz) blink_d = ~blink_q;
          if (cnt_fire) begin
            min_en_d  = 1'b1;
            up_down_d = btn_u;
          end
        end
      end
      default: begin
        mode_d    = MODE_RUN;
        blink_d   = 1'b0;
        up_down_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_RUN;
      sec_en_q  <= 1'b0;
      min_en_q  <= 1'b0;
      hr_en_q   <= 1'b0;
      up_down_q <= 1'b1;
      blink_q   <= 1'b0;
      btn_c_q   <= 1'b0;
      btn_u_q   <= 1'b0;
      btn_d_q   <= 1'b0;
      hold_q    <= '0;
      rep_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      sec_en_q  <= sec_en_d;
      min_en_q  <= min_en_d;
      hr_en_q   <= hr_en_d;
      up_down_q <= up_down_d;
      blink_q   <= blink_d;
      btn_c_q   <= btn_c;
      btn_u_q   <= btn_u;
      btn_d_q   <= btn_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
    end
  end

  assign sec_en  = sec_en_q;
  assign min_en  = min_en_q;
  assign hr_en   = hr_en_q;
  assign up_down = up_down_q;
  assign mode    = mode_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Directed bench for time_adjust_ctrl with HOLD_CYCLES=8, REPEAT_CYCLES=4.
module tb_time_adjust_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz, btn_c, btn_u, btn_d, sec_tc, min_tc;
  logic       sec_en, min_en, hr_en, up_down, blink;
  logic [1:0] mode;

  int checks   = 0;
  int failures = 0;

  time_adjust_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d),
    .sec_tc(sec_tc), .min_tc(min_tc),
    .sec_en(sec_en), .min_en(min_en), .hr_en(hr_en),
    .up_down(up_down), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_c();
    btn_c = 1'b1; step();
    btn_c = 1'b0; step();
  endtask

  initial begin
    rst = 1'b0; tick_1hz = 0; btn_c = 0; btn_u = 0; btn_d = 0; sec_tc = 0; min_tc = 0;
    #12;
    check_val("rst_mode", mode, 2'b00);
    check_val("rst_sec_en", sec_en, 0);
    check_val("rst_hr_en", hr_en, 0);
    check_val("rst_up_down", up_down, 1);
    check_val("rst_blink", blink, 0);
    step();
    rst = 1'b1;
    step();

    // RUN cascade
    sec_tc = 1; min_tc = 1; tick_1hz = 1; step();
    check_val("run_sec_en", sec_en, 1);
    check_val("run_min_en", min_en, 1);
    check_val("run_hr_en", hr_en, 1);
    check_val("run_up_down", up_down, 1);
    tick_1hz = 0; step();
    check_val("run_cascade_one_cycle", {sec_en, min_en, hr_en}, 3'b000);
    sec_tc = 0; tick_1hz = 1; step();
    check_val("run_sec_only", {sec_en, min_en, hr_en}, 3'b100);
    tick_1hz = 0; min_tc = 0; step();
    check_val("run_sec_drop", sec_en, 0);

    // RUN -> SET_HR, blink on ticks, time frozen
    btn_c = 1; step();
    check_val("mode_set_hr", mode, 2'b01);
    btn_c = 0; step();
    tick_1hz = 1; step();
    check_val("sethr_sec_frozen", sec_en, 0);
    check_val("sethr_blink1", blink, 1);
    tick_1hz = 0; step();
    check_val("sethr_blink_hold", blink, 1);
    tick_1hz = 1; step();
    check_val("sethr_blink0", blink, 0);
    tick_1hz = 0;
    btn_c = 1; step();
    check_val("mode_set_min", mode, 2'b10);
    btn_c = 0; step();
    tick_1hz = 1; step();
    check_val("setmin_blink1", blink, 1);
    tick_1hz = 0;
    btn_c = 1; step();
    check_val("mode_run", mode, 2'b00);
    check_val("run_blink_cleared", blink, 0);
    btn_c = 0; step();

    // SET_MIN: btn_d held 2 cycles -> one min_en pulse, down
    press_c(); press_c();
    check_val("mode_set_min2", mode, 2'b10);
    btn_d = 1; step();
    check_val("dn_min_en", min_en, 1);
    check_val("dn_up_down", up_down, 0);
    check_val("dn_hr_en", hr_en, 0);
    step();
    check_val("dn_min_en_once", min_en, 0);
    check_val("dn_up_down_hold", up_down, 0);
    btn_d = 0; step();
    check_val("dn_min_en_rel", min_en, 0);

    // Back to RUN, then SET_HR; btn_u held 20 cycles -> pulses at 1,8,12,16,20
    press_c(); press_c();
    check_val("mode_set_hr2", mode, 2'b01);
    btn_u = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check_val($sformatf("rep_hr_en_k%0d", k), hr_en,
                (k == 1 || k == 8 || k == 12 || k == 16 || k == 20) ? 1 : 0);
      check_val($sformatf("rep_min_en_k%0d", k), min_en, 0);
      if (hr_en) check_val($sformatf("rep_up_down_k%0d", k), up_down, 1);
    end
    btn_u = 0; step();
    check_val("rep_rel_hr_en", hr_en, 0);

    // Both held: no pulses; release btn_d -> fresh hold count
    btn_u = 1; btn_d = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check_val($sformatf("both_hr_en_k%0d", k), hr_en, 0);
    end
    btn_d = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_val($sformatf("solo_hr_en_k%0d", k), hr_en, (k == 8 || k == 12) ? 1 : 0);
      if (k == 8) check_val("solo_up_down", up_down, 1);
    end

    // hr_en high now: async reset must drop it without a clock edge
    #1;
    rst = 1'b0;
    #1;
    check_val("async_hr_en", hr_en, 0);
    check_val("async_mode", mode, 2'b00);
    step();
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_val($sformatf("post_rst_hr_en_k%0d", k), hr_en, 0);
      check_val($sformatf("post_rst_mode_k%0d", k), mode, 2'b00);
    end
    btn_u = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
